// File: rtl/uc_pkg.sv
// Shared opcodes, ALU constants, FSM state encoding and decoded-control bundle for uc_ctrl.
// UC_ILLEGAL_TRAP_EN selects whether undefined opcodes trap or run as NOP.
package uc_pkg;

   localparam logic [5:0] OP_J    = 6'b000100;
   localparam logic [5:0] OP_JZ   = 6'b000101;
   localparam logic [5:0] OP_JNZ  = 6'b000110;
   localparam logic [5:0] OP_HALT = 6'b000111;
   localparam logic [3:0] OP_LDI  = 4'b0000;

   localparam logic [2:0] ALU_PASSB = 3'b000;

`ifdef UC_ILLEGAL_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_STEP  = 3'd3,
      S_HALT  = 3'd4,
      S_TRAP  = 3'd5
   } state_t;

   typedef struct packed {
      logic       s_inc;
      logic       s_inm;
      logic       we3;
      logic       wez;
      logic [2:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0,
                                   wez: 1'b0, alu_op: 3'b000};

endpackage

// File: rtl/uc_decode.sv
// Combinational instruction decode: Opcode/zero to raw datapath controls,
// plus HALT and undefined-opcode flags. Gating by execution state lives in uc_ctrl.
module uc_decode
   import uc_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic       i_zero,
   output ctrl_t      o_ctrl,
   output logic       o_is_halt,
   output logic       o_is_illegal
);

   always_comb begin
      o_ctrl       = CTRL_IDLE;
      o_is_halt    = 1'b0;
      o_is_illegal = 1'b0;
      if (i_opcode[5]) begin
         o_ctrl.alu_op = i_opcode[4:2];
         o_ctrl.we3    = 1'b1;
         o_ctrl.wez    = 1'b1;
      end else if (i_opcode[5:2] == OP_LDI) begin
         o_ctrl.s_inm  = 1'b1;
         o_ctrl.alu_op = ALU_PASSB;
         o_ctrl.we3    = 1'b1;
      end else begin
         case (i_opcode)
            OP_J:    o_ctrl.s_inc = 1'b0;
            OP_JZ:   o_ctrl.s_inc = ~i_zero;
            OP_JNZ:  o_ctrl.s_inc = i_zero;
            OP_HALT: o_is_halt    = 1'b1;
            default: o_is_illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/uc_ctrl.sv
// Microcontroller control unit: decode gating, run/pause/step/halt supervision,
// retired-instruction counter. UC_ILLEGAL_TRAP_EN enables the illegal-opcode trap state.
//
// state   | meaning
// S_INIT  | post-reset hold for RST_CYCLES cycles, nothing executes
// S_RUN   | free-run, one instruction per cycle
// S_PAUSE | stopped, waiting for run or an armed step request
// S_STEP  | executes exactly one instruction, then back to S_PAUSE
// S_HALT  | HALT retired, frozen until reset
// S_TRAP  | undefined opcode seen (trap build only), frozen until reset
module uc_ctrl
   import uc_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int RST_CYCLES = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       Opcode,
   input  logic             zero,
   input  logic             run,
   input  logic             step_req,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic             wez,
   output logic [2:0]       ALUOp,
   output logic             pc_en,
   output logic             halted,
   output logic             step_ack,
   output logic [CNT_W-1:0] icount,
   output logic             illegal
);

   localparam int              INIT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(RST_CYCLES - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [INIT_W-1:0]  r_init_cnt;
   logic               r_step_armed;
   logic               r_step_ack;
   logic [CNT_W-1:0]   r_icount;

   ctrl_t              w_dec;
   logic               w_is_halt;
   logic               w_is_illegal;
   logic               w_trap;
   logic               w_exec;

   uc_decode u_decode (
      .i_opcode     (Opcode),
      .i_zero       (zero),
      .o_ctrl       (w_dec),
      .o_is_halt    (w_is_halt),
      .o_is_illegal (w_is_illegal)
   );

   // HALT and trapped opcodes never count as executing: no PC update, no writes.
   assign w_trap = TRAP_EN & w_is_illegal;
   assign w_exec = ((r_state == S_RUN) || (r_state == S_STEP)) & ~w_is_halt & ~w_trap;

   always_comb begin
      s_inc = 1'b1;
      s_inm = 1'b0;
      we3   = 1'b0;
      wez   = 1'b0;
      ALUOp = 3'b000;
      pc_en = 1'b0;
      if (w_exec) begin
         s_inc = w_dec.s_inc;
         s_inm = w_dec.s_inm;
         we3   = w_dec.we3;
         wez   = w_dec.wez;
         ALUOp = w_dec.alu_op;
         pc_en = 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_INIT:  if (r_init_cnt == INIT_LAST) w_state_nxt = run ? S_RUN : S_PAUSE;
         S_RUN: begin
            if (w_is_halt)   w_state_nxt = S_HALT;
            else if (w_trap) w_state_nxt = S_TRAP;
            else if (!run)   w_state_nxt = S_PAUSE;
         end
         S_PAUSE: begin
            if (run)                           w_state_nxt = S_RUN;
            else if (step_req && r_step_armed) w_state_nxt = S_STEP;
         end
         S_STEP: begin
            if (w_is_halt)   w_state_nxt = S_HALT;
            else if (w_trap) w_state_nxt = S_TRAP;
            else             w_state_nxt = S_PAUSE;
         end
         S_HALT:  w_state_nxt = S_HALT;
         S_TRAP:  w_state_nxt = S_TRAP;
         default: w_state_nxt = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_INIT;
         r_init_cnt   <= '0;
         r_step_armed <= 1'b1;
         r_step_ack   <= 1'b0;
         r_icount     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_INIT && r_init_cnt != INIT_LAST)
            r_init_cnt <= r_init_cnt + INIT_W'(1);
         // A step request must be seen low before it can trigger another step.
         if (!step_req)
            r_step_armed <= 1'b1;
         else if (r_state == S_PAUSE && !run && r_step_armed)
            r_step_armed <= 1'b0;
         r_step_ack <= (r_state == S_STEP);
         if (w_exec && r_icount != '1)
            r_icount <= r_icount + CNT_W'(1);
      end
   end

   assign step_ack = r_step_ack;
   assign icount   = r_icount;

`ifdef UC_ILLEGAL_TRAP_EN
   assign halted  = (r_state == S_HALT) || (r_state == S_TRAP);
   assign illegal = (r_state == S_TRAP);
`else
   assign halted  = (r_state == S_HALT);
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_uc_ctrl.sv
// Self-checking bench for uc_ctrl: decode table in S_RUN plus hand-written
// pause/step, HALT, reset-abort and undefined-opcode sequences.
module tb_uc_ctrl;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [5:0]       Opcode;
   logic             zero;
   logic             run;
   logic             step_req;
   logic             s_inc, s_inm, we3, wez, pc_en, halted, step_ack, illegal;
   logic [2:0]       ALUOp;
   logic [CNT_W-1:0] icount;

   always #5 clk = ~clk;

   uc_ctrl #(.CNT_W(CNT_W), .RST_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .run(run),
      .step_req(step_req), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
      .ALUOp(ALUOp), .pc_en(pc_en), .halted(halted), .step_ack(step_ack),
      .icount(icount), .illegal(illegal)
   );

   typedef struct {
      logic             s_inc, s_inm, we3, wez;
      logic [2:0]       alu;
      logic             pc_en, halted, ack, ill;
      logic [CNT_W-1:0] icount;
   } exp_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      exp_t       e;
   } vec_t;

   exp_t             exp_q[$];
   vec_t             vt[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   logic [CNT_W-1:0] exp_icount = '0;

   function automatic exp_t mk(logic inc, logic inm, logic we, logic wz, logic [2:0] alu,
                               logic pc, logic h, logic ack, logic ill);
      exp_t e;
      e.s_inc = inc; e.s_inm = inm; e.we3 = we; e.wez = wz; e.alu = alu;
      e.pc_en = pc; e.halted = h; e.ack = ack; e.ill = ill; e.icount = '0;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic addv(input logic [5:0] op, input logic z, input exp_t e);
      vec_t v;
      v.op = op; v.z = z; v.e = e;
      vt.push_back(v);
   endtask

   // Entered just after a rising edge: drive, push expectation, compare at the
   // falling edge, update the icount model, then move past the next rising edge.
   task automatic cyc(input string nm, input logic [5:0] op, input logic z,
                      input logic r, input logic sr, input exp_t e);
      exp_t g;
      Opcode = op; zero = z; run = r; step_req = sr;
      e.icount = exp_icount;
      exp_q.push_back(e);
      @(negedge clk);
      g = exp_q.pop_front();
      chk({nm, ".s_inc"},    32'(s_inc),    32'(g.s_inc));
      chk({nm, ".s_inm"},    32'(s_inm),    32'(g.s_inm));
      chk({nm, ".we3"},      32'(we3),      32'(g.we3));
      chk({nm, ".wez"},      32'(wez),      32'(g.wez));
      chk({nm, ".ALUOp"},    32'(ALUOp),    32'(g.alu));
      chk({nm, ".pc_en"},    32'(pc_en),    32'(g.pc_en));
      chk({nm, ".halted"},   32'(halted),   32'(g.halted));
      chk({nm, ".step_ack"}, 32'(step_ack), 32'(g.ack));
      chk({nm, ".illegal"},  32'(illegal),  32'(g.ill));
      chk({nm, ".icount"},   32'(icount),   32'(g.icount));
      if (g.pc_en && exp_icount != '1) exp_icount++;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      exp_icount = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t idle, idle_ack, idle_h, idle_h_ack, alu3;
      idle       = mk(1, 0, 0, 0, 3'b000, 0, 0, 0, 0);
      idle_ack   = mk(1, 0, 0, 0, 3'b000, 0, 0, 1, 0);
      idle_h     = mk(1, 0, 0, 0, 3'b000, 0, 1, 0, 0);
      idle_h_ack = mk(1, 0, 0, 0, 3'b000, 0, 1, 1, 0);
      alu3       = mk(1, 0, 1, 1, 3'b011, 1, 0, 0, 0);

      addv(6'b101100, 1'b0, alu3);
      addv(6'b000010, 1'b0, mk(1, 1, 1, 0, 3'b000, 1, 0, 0, 0));
      addv(6'b111111, 1'b1, mk(1, 0, 1, 1, 3'b111, 1, 0, 0, 0));
      addv(6'b100011, 1'b0, mk(1, 0, 1, 1, 3'b000, 1, 0, 0, 0));
      addv(6'b000101, 1'b1, mk(0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      addv(6'b000101, 1'b0, mk(1, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      addv(6'b000110, 1'b1, mk(1, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      addv(6'b000110, 1'b0, mk(0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      addv(6'b000100, 1'b0, mk(0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      addv(6'b000100, 1'b1, mk(0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      addv(6'b000011, 1'b1, mk(1, 1, 1, 0, 3'b000, 1, 0, 0, 0));

      reset = 1'b0; run = 1'b1; step_req = 1'b0; Opcode = 6'b101100; zero = 1'b0;
      #3;
      chk("rst.pc_en",    32'(pc_en),    32'd0);
      chk("rst.we3",      32'(we3),      32'd0);
      chk("rst.halted",   32'(halted),   32'd0);
      chk("rst.step_ack", 32'(step_ack), 32'd0);
      chk("rst.icount",   32'(icount),   32'd0);
      chk("rst.illegal",  32'(illegal),  32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      cyc("init0", 6'b101100, 0, 1, 0, idle);
      cyc("init1", 6'b101100, 0, 1, 0, idle);

      foreach (vt[i]) cyc($sformatf("vec%0d", i), vt[i].op, vt[i].z, 1'b1, 1'b0, vt[i].e);

      cyc("run_drop", 6'b101100, 0, 0, 0, alu3);
      for (int k = 0; k < 5; k++)
         cyc($sformatf("step_hold%0d", k), 6'b101100, 0, 0, 1,
             (k == 1) ? alu3 : ((k == 2) ? idle_ack : idle));
      cyc("step_rel",  6'b000100, 0, 0, 0, idle);
      cyc("step2_req", 6'b000100, 0, 0, 1, idle);
      cyc("step2_ex",  6'b000100, 0, 0, 0, mk(0, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      cyc("step2_ack", 6'b000100, 0, 0, 0, idle_ack);
      cyc("resume",    6'b101100, 0, 1, 0, idle);
      cyc("resume_ex", 6'b101100, 0, 1, 0, alu3);
      cyc("halt_dec",  6'b000111, 0, 1, 0, idle);
      for (int k = 0; k < 4; k++)
         cyc($sformatf("halted%0d", k), 6'b101100, 0, logic'(k & 1), logic'(~k & 1), idle_h);

      #2;
      reset = 1'b0;
      #1;
      chk("halt_rst.halted", 32'(halted), 32'd0);
      chk("halt_rst.icount", 32'(icount), 32'd0);
      chk("halt_rst.pc_en",  32'(pc_en),  32'd0);
      exp_icount = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      cyc("abort_init0", 6'b101100, 0, 1, 0, idle);
      cyc("abort_init1", 6'b101100, 0, 1, 0, idle);
      #2;
      chk("abort_pre.we3", 32'(we3), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort.we3",   32'(we3),   32'd0);
      chk("abort.wez",   32'(wez),   32'd0);
      chk("abort.pc_en", 32'(pc_en), 32'd0);
      exp_icount = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;

      cyc("sh_init0", 6'b000111, 0, 0, 0, idle);
      cyc("sh_init1", 6'b000111, 0, 0, 0, idle);
      cyc("sh_req",   6'b000111, 0, 0, 1, idle);
      cyc("sh_step",  6'b000111, 0, 0, 0, idle);
      cyc("sh_ack",   6'b000111, 0, 1, 0, idle_h_ack);
      cyc("sh_after", 6'b000111, 0, 1, 1, idle_h);

      pulse_reset();
      cyc("tr_init0", 6'b001000, 0, 1, 0, idle);
      cyc("tr_init1", 6'b001000, 0, 1, 0, idle);
`ifdef UC_ILLEGAL_TRAP_EN
      cyc("trap_dec", 6'b001000, 0, 1, 0, idle);
      cyc("trap_st",  6'b000010, 0, 1, 0, mk(1, 0, 0, 0, 3'b000, 0, 1, 0, 1));
`else
      cyc("nop_ex",   6'b001000, 0, 1, 0, mk(1, 0, 0, 0, 3'b000, 1, 0, 0, 0));
      cyc("nop_next", 6'b000010, 0, 1, 0, mk(1, 1, 1, 0, 3'b000, 1, 0, 0, 0));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
